// File: rtl/lattice_scheduler.sv
// lattice_scheduler: feeds nonce batches into the systolic lattice head
// and matches tail results back to nonces, reporting a hit or exhaustion.
module lattice_scheduler #(
  parameter int NUM_CORES    = 10,
  parameter int NONCE_W      = 32,
  parameter int WORK_W       = 352,
  parameter int MAX_INFLIGHT = 16,
  parameter int COUNTBITS    = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 work_valid,
  output logic                 work_ready,
  input  logic [WORK_W-1:0]    work_data,
  input  logic [NONCE_W-1:0]   nonce_start,
  input  logic [NONCE_W-1:0]   nonce_end,
  input  logic                 abort,
  output logic                 issue_valid,
  output logic [WORK_W-1:0]    issue_work,
  output logic [NONCE_W-1:0]   issue_nonce,
  input  logic                 res_valid,
  input  logic                 res_success,
  input  logic [COUNTBITS-1:0] res_index,
  output logic                 found_valid,
  output logic [NONCE_W-1:0]   found_nonce,
  output logic                 done_valid,
  output logic                 busy,
  output logic                 err
);

  localparam int IW  = $clog2(MAX_INFLIGHT + 1);
  localparam int NW1 = NONCE_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        inflight_q, inflight_d;
  logic [NONCE_W-1:0]   end_q, end_d;
  logic [NONCE_W-1:0]   res_base_q, res_base_d;
  logic [NONCE_W-1:0]   issue_nonce_q, issue_nonce_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [WORK_W-1:0]    issue_work_q, issue_work_d;
  logic                 hit_q, hit_d;
  logic                 abort_q, abort_d;
  logic                 err_q, err_d;
  logic                 issue_valid_q, issue_valid_d;
  logic                 found_valid_q, found_valid_d;
  logic                 done_valid_q, done_valid_d;
  logic                 work_ready_q, work_ready_d;
  logic                 busy_q, busy_d;

  logic [NW1-1:0]       next_base;
  logic [NW1-1:0]       last_nonce;
  logic [NW1-1:0]       cand;
  logic                 res_ok;
  logic                 hit_now;
  logic                 last_fire;

  // Sums are one bit wider so a carry past the top nonce is visible
  always_comb begin
    next_base  = {1'b0, issue_nonce_q} + NW1'(NUM_CORES);
    last_nonce = {1'b0, issue_nonce_q} + NW1'(NUM_CORES - 1);
    cand       = {1'b0, res_base_q} + NW1'(res_index);
    res_ok     = res_valid && (inflight_q != '0);
    last_fire  = issue_valid_q && (last_nonce >= {1'b0, end_q});
    hit_now    = res_ok && res_success && !hit_q && !abort_q
              && !cand[NONCE_W] && (cand[NONCE_W-1:0] <= end_q);
  end

  always_comb begin
    state_d       = state_q;
    end_d         = end_q;
    res_base_d    = res_base_q;
    issue_nonce_d = issue_nonce_q;
    found_nonce_d = found_nonce_q;
    issue_work_d  = issue_work_q;
    hit_d         = hit_q;
    abort_d       = abort_q;
    err_d         = err_q;
    issue_valid_d = 1'b0;
    found_valid_d = 1'b0;
    done_valid_d  = 1'b0;

    inflight_d = inflight_q + IW'(issue_valid_q) - IW'(res_ok);
    if (res_valid && !res_ok) err_d = 1'b1;
    if (issue_valid_q) issue_nonce_d = next_base[NONCE_W-1:0];
    if (res_ok) res_base_d = res_base_q + NONCE_W'(NUM_CORES);
    if (hit_now) begin
      found_nonce_d = cand[NONCE_W-1:0];
      found_valid_d = 1'b1;
      hit_d         = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (work_valid) begin
          issue_work_d  = work_data;
          end_d         = nonce_end;
          issue_nonce_d = nonce_start;
          res_base_d    = nonce_start;
          hit_d         = 1'b0;
          abort_d       = 1'b0;
          issue_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) abort_d = 1'b1;
        if (abort || hit_now || last_fire) begin
          state_d = DRAIN;
        end else begin
          issue_valid_d = inflight_d < IW'(MAX_INFLIGHT);
        end
      end
      DRAIN: begin
        if (abort) abort_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A stop with nothing outstanding finishes without lingering in DRAIN
    if (state_d == DRAIN && inflight_d == '0) begin
      state_d      = IDLE;
      done_valid_d = !hit_d;
    end

    work_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      inflight_q    <= '0;
      end_q         <= '0;
      res_base_q    <= '0;
      issue_nonce_q <= '0;
      found_nonce_q <= '0;
      issue_work_q  <= '0;
      hit_q         <= 1'b0;
      abort_q       <= 1'b0;
      err_q         <= 1'b0;
      issue_valid_q <= 1'b0;
      found_valid_q <= 1'b0;
      done_valid_q  <= 1'b0;
      work_ready_q  <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      end_q         <= end_d;
      res_base_q    <= res_base_d;
      issue_nonce_q <= issue_nonce_d;
      found_nonce_q <= found_nonce_d;
      issue_work_q  <= issue_work_d;
      hit_q         <= hit_d;
      abort_q       <= abort_d;
      err_q         <= err_d;
      issue_valid_q <= issue_valid_d;
      found_valid_q <= found_valid_d;
      done_valid_q  <= done_valid_d;
      work_ready_q  <= work_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign work_ready  = work_ready_q;
  assign issue_valid = issue_valid_q;
  assign issue_work  = issue_work_q;
  assign issue_nonce = issue_nonce_q;
  assign found_valid = found_valid_q;
  assign found_nonce = found_nonce_q;
  assign done_valid  = done_valid_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lattice_scheduler.sv
// tb_lattice_scheduler: random jobs against a fixed-latency lattice model,
// with expected issues, hits and completion derived from nonce arithmetic.
module tb_lattice_scheduler;

  localparam int NC = 10;
  localparam int NW = 32;
  localparam int WW = 352;
  localparam int MI = 4;
  localparam int CB = 4;
  localparam longint TOP = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          work_valid;
  logic          work_ready;
  logic [WW-1:0] work_data;
  logic [NW-1:0] nonce_start;
  logic [NW-1:0] nonce_end;
  logic          abort;
  logic          issue_valid;
  logic [WW-1:0] issue_work;
  logic [NW-1:0] issue_nonce;
  logic          res_valid;
  logic          res_success;
  logic [CB-1:0] res_index;
  logic          found_valid;
  logic [NW-1:0] found_nonce;
  logic          done_valid;
  logic          busy;
  logic          err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lattice_scheduler #(
    .NUM_CORES(NC),
    .NONCE_W(NW),
    .WORK_W(WW),
    .MAX_INFLIGHT(MI),
    .COUNTBITS(CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .work_valid(work_valid),
    .work_ready(work_ready),
    .work_data(work_data),
    .nonce_start(nonce_start),
    .nonce_end(nonce_end),
    .abort(abort),
    .issue_valid(issue_valid),
    .issue_work(issue_work),
    .issue_nonce(issue_nonce),
    .res_valid(res_valid),
    .res_success(res_success),
    .res_index(res_index),
    .found_valid(found_valid),
    .found_nonce(found_nonce),
    .done_valid(done_valid),
    .busy(busy),
    .err(err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_iv"}, issue_valid, 1'b0);
    chk({tag, "_fv"}, found_valid, 1'b0);
    chk({tag, "_dv"}, done_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_wr"}, work_ready, 1'b1);
    chk({tag, "_fn"}, found_nonce, 0);
    chk({tag, "_in"}, issue_nonce, 0);
    chk({tag, "_iw"}, issue_work == '0, 1'b1);
  endtask

  // mode 0: no success; 1: hit at t inside the range; 2: success at t past end
  task automatic run_job(input longint s, input longint e, input int lat,
                         input int mode, input longint t, input int abort_at);
    longint nb, b;
    int n_iss, n_res, hit_b, k, bi;
    int found_k, done_k, end_k;
    bit stopped, hit_seen, exp_iv;
    logic [WW-1:0] data;
    int due_q[$];
    int idx_q[$];
    nb = (e - s) / NC + 1;
    hit_b = (mode == 1) ? int'((t - s) / NC) : -1;
    n_iss = 0; n_res = 0; stopped = 0; hit_seen = 0;
    found_k = -1; done_k = -1; end_k = -1;
    for (int w = 0; w < WW / 32; w++) data[w*32 +: 32] = $urandom;
    abort = 0; res_valid = 0; res_success = 0; res_index = '0;
    work_data = data;
    nonce_start = s[NW-1:0];
    nonce_end = e[NW-1:0];
    work_valid = 1;
    chk("ready_pre", work_ready, 1'b1);
    @(negedge clk);
    work_valid = 0;
    k = 1;
    forever begin
      exp_iv = !stopped && (n_iss < nb) && ((n_iss - n_res) < MI);
      chk("issue_valid", issue_valid, exp_iv);
      if (issue_valid) begin
        b = s + longint'(NC) * n_iss;
        chk("issue_nonce", issue_nonce, b[NW-1:0]);
        chk("issue_work", issue_work == data, 1'b1);
        due_q.push_back(k + lat);
        idx_q.push_back(n_iss);
        n_iss++;
      end
      chk("found_valid", found_valid, k == found_k);
      if (k == found_k) chk("found_nonce", found_nonce, t[NW-1:0]);
      chk("done_valid", done_valid, k == done_k);
      chk("busy", busy, k != end_k);
      chk("work_ready", work_ready, k == end_k);
      if (k == end_k) break;
      if (k > 3000) begin
        chk("timeout", 0, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        break;
      end
      abort = (k == abort_at);
      if (abort) stopped = 1;
      res_valid = 0; res_success = 0; res_index = '0;
      if (due_q.size() > 0 && due_q[0] <= k) begin
        void'(due_q.pop_front());
        bi = idx_q.pop_front();
        b = s + longint'(NC) * bi;
        res_valid = 1;
        if (mode != 0 && t >= b && t <= b + NC - 1) begin
          res_success = 1;
          res_index = CB'(t - b);
        end else if (hit_b >= 0 && bi > hit_b && $urandom_range(0, 1) == 1) begin
          res_success = 1;
          res_index = CB'($urandom_range(0, NC - 1));
        end
        n_res++;
        if (mode == 1 && bi == hit_b) begin
          found_k = k + 1;
          stopped = 1;
          hit_seen = 1;
        end
      end
      if (end_k < 0 && n_res == n_iss && (stopped || n_iss == nb)) begin
        end_k = k + 1;
        if (!hit_seen) done_k = k + 1;
      end
      @(negedge clk);
      k++;
    end
    abort = 0; res_valid = 0; res_success = 0; res_index = '0;
    chk("err_clear", err, 1'b0);
  endtask

  initial begin
    longint s, e, t, lastb, nb;
    int mode, ab, lat;
    rst = 1; work_valid = 0; abort = 0;
    res_valid = 0; res_success = 0; res_index = '0;
    work_data = '0; nonce_start = '0; nonce_end = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    rst = 0;
    @(negedge clk);

    run_job(0, 29, 5, 0, 0, -1);
    run_job(100, 999, 5, 1, 117, -1);
    run_job(0, 24, 3, 2, 26, -1);
    run_job(TOP - 15, TOP, 4, 2, 64'h1_0000_0003, -1);
    run_job(1000, 1299, 10, 0, 0, -1);
    run_job(0, 9999, 6, 0, 0, 8);

    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 3) == 0) s = TOP - $urandom_range(0, 60);
      else s = {32'h0, $urandom};
      e = s + $urandom_range(0, 60);
      if (e > TOP) e = TOP;
      nb = (e - s) / NC + 1;
      lastb = s + NC * (nb - 1);
      lat = $urandom_range(1, 12);
      mode = $urandom_range(0, 2);
      if (mode == 2 && lastb + NC - 1 <= e) mode = 0;
      t = 0;
      if (mode == 1) t = s + $urandom_range(0, int'(e - s));
      if (mode == 2) t = e + 1 + $urandom_range(0, int'(lastb + NC - 2 - e));
      ab = -1;
      if (mode != 1 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(1, int'(nb) + lat);
      run_job(s, e, lat, mode, t, ab);
    end

    @(negedge clk);
    res_valid = 1;
    @(negedge clk);
    res_valid = 0;
    chk("err_set", err, 1'b1);
    chk("err_idle", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1'b1);

    nonce_start = 0;
    nonce_end = 99999;
    work_valid = 1;
    @(negedge clk);
    work_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    chk("mid_iv", issue_valid, 1'b1);
    rst = 1;
    @(negedge clk);
    chk_reset_state("mid_rst");
    rst = 0;
    @(negedge clk);
    run_job(5, 54, 2, 1, 33, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
